// File: rtl/ozphy_pkg.sv
// Shared symbol constants, state/mode enums and the TS symbol table
// for the per-lane transmit ordered-set scheduler.
package ozphy_pkg;

    localparam logic [7:0] COM       = 8'hBC;
    localparam logic [7:0] PAD       = 8'hF7;
    localparam logic [7:0] SKP       = 8'h1C;
    localparam logic [7:0] TS1_ID    = 8'h4A;
    localparam logic [7:0] TS2_ID    = 8'h45;
    localparam logic [7:0] RATE_GEN1 = 8'h02;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TS,
        S_SKP,
        S_DATA
    } state_e;

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_TS1,
        MODE_TS2,
        MODE_DATA
    } mode_e;

    // Returns {k, symbol} for TS index idx of a TS1 (ts2=0) or TS2 set.
    function automatic logic [8:0] ts_symbol(
        input logic [3:0] idx,
        input logic       ts2,
        input logic       pad,
        input logic [7:0] lnk,
        input logic [7:0] lan,
        input logic [7:0] n_fts
    );
        logic [8:0] r;
        unique case (idx)
            4'd0:    r = {1'b1, COM};
            4'd1:    r = pad ? {1'b1, PAD} : {1'b0, lnk};
            4'd2:    r = pad ? {1'b1, PAD} : {1'b0, lan};
            4'd3:    r = {1'b0, n_fts};
            4'd4:    r = {1'b0, RATE_GEN1};
            4'd5:    r = {1'b0, 8'h00};
            default: r = {1'b0, ts2 ? TS2_ID : TS1_ID};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ozphy_skp_timer.sv
// SKP interval timer: counts active cycles and holds a single
// pending SKP request until the scheduler issues the SKP COM.
module ozphy_skp_timer
    import ozphy_pkg::*;
#(
    parameter int INTERVAL = 1180
) (
    input  logic clk,
    input  logic reset,
    input  logic hold,
    input  logic clear,
    output logic skp_pending
);

    localparam int W = $clog2(INTERVAL);

    logic [W-1:0] cnt;

    // Count active cycles; an expiry wins over a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            skp_pending <= 1'b0;
        end else if (hold) begin
            cnt         <= '0;
            skp_pending <= 1'b0;
        end else if (cnt == W'(INTERVAL - 1)) begin
            cnt         <= '0;
            skp_pending <= 1'b1;
        end else begin
            cnt <= cnt + W'(1);
            if (clear) begin
                skp_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ozphy_tx_os_scheduler.sv
// Per-lane TX scheduler: picks idle, TS1/TS2, SKP or link data for
// the encoder each symbol clock and tracks completed training sets.
module ozphy_tx_os_scheduler
    import ozphy_pkg::*;
#(
    parameter int         NTS          = 1024,
    parameter int         SKP_INTERVAL = 1180,
    parameter logic [7:0] N_FTS        = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic [7:0] link_num,
    input  logic [7:0] lane_num,
    input  logic       use_pad,
    input  logic       data_valid,
    input  logic [7:0] data,
    input  logic       datak,
    output logic       data_ready,
    output logic [7:0] txdata,
    output logic       txdatak,
    output logic       txelecidle,
    output logic       ts_done,
    output logic       skp_sent
);

    // state/sym_idx describe the symbol issued last cycle;
    // cur_* describe the symbol being chosen this cycle.
    state_e      state;
    state_e      cur_state;
    state_e      dec_state;
    logic [3:0]  sym_idx;
    logic [3:0]  cur_idx;
    logic        boundary;
    logic        skp_pending;
    logic        ts2_q;
    logic        cur_ts2;
    logic [15:0] ts_cnt;
    logic [8:0]  ts_sym;
    mode_e       mode_sel;

    assign mode_sel = mode_e'(mode);

    // Boundary detection, priority decision and current symbol slot.
    always_comb begin
        boundary  = 1'b1;
        dec_state = S_TS;
        cur_state = state;
        cur_idx   = sym_idx + 4'd1;
        unique case (state)
            S_TS:    boundary = (sym_idx == 4'd15);
            S_SKP:   boundary = (sym_idx == 4'd3);
            default: boundary = 1'b1;
        endcase
        if (mode_sel == MODE_IDLE) begin
            dec_state = S_IDLE;
        end else if (skp_pending) begin
            dec_state = S_SKP;
        end else if (mode_sel == MODE_DATA) begin
            dec_state = S_DATA;
        end
        if (boundary) begin
            cur_state = dec_state;
            cur_idx   = 4'd0;
        end
    end

    assign data_ready = boundary && (mode_sel == MODE_DATA) && !skp_pending;

    assign cur_ts2 = (cur_idx == 4'd0) ? (mode_sel == MODE_TS2) : ts2_q;

    assign ts_sym = ts_symbol(cur_idx, cur_ts2, use_pad,
                              link_num, lane_num, N_FTS);

    assign ts_done = (ts_cnt == 16'(NTS));

    // State register: remembers the slot just issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            sym_idx <= 4'd0;
        end else begin
            state   <= cur_state;
            sym_idx <= cur_idx;
        end
    end

    // Registered symbol, K flag and status outputs to the encoder.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txdata     <= 8'h00;
            txdatak    <= 1'b0;
            txelecidle <= 1'b1;
            skp_sent   <= 1'b0;
        end else begin
            txelecidle <= (cur_state == S_IDLE);
            skp_sent   <= (cur_state == S_SKP) && (cur_idx == 4'd3);
            unique case (cur_state)
                S_TS: begin
                    {txdatak, txdata} <= ts_sym;
                end
                S_SKP: begin
                    txdata  <= (cur_idx == 4'd0) ? COM : SKP;
                    txdatak <= 1'b1;
                end
                S_DATA: begin
                    if (data_valid) begin
                        {txdatak, txdata} <= {datak, data};
                    end else begin
                        {txdatak, txdata} <= 9'h000;
                    end
                end
                default: begin
                    {txdatak, txdata} <= 9'h000;
                end
            endcase
        end
    end

    // TS type latch and saturating count of completed sets.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_cnt <= 16'd0;
            ts2_q  <= 1'b0;
        end else if (cur_state == S_IDLE) begin
            ts_cnt <= 16'd0;
        end else if (cur_state == S_TS) begin
            if (cur_idx == 4'd0) begin
                ts2_q <= cur_ts2;
                if (cur_ts2 != ts2_q) begin
                    ts_cnt <= 16'd0;
                end
            end else if (cur_idx == 4'd15 && ts_cnt != 16'(NTS)) begin
                ts_cnt <= ts_cnt + 16'd1;
            end
        end
    end

    ozphy_skp_timer #(
        .INTERVAL (SKP_INTERVAL)
    ) u_skp_timer (
        .clk         (clk),
        .reset       (reset),
        .hold        (cur_state == S_IDLE),
        .clear       ((cur_state == S_SKP) && (cur_idx == 4'd0)),
        .skp_pending (skp_pending)
    );

endmodule

// File: tb/tb_ozphy_tx_os_scheduler.sv
// Bench for the TX ordered-set scheduler: a set-queue reference model
// predicts every symbol, flag and handshake cycle by cycle.
module tb_ozphy_tx_os_scheduler;

    localparam int NTS          = 4;
    localparam int SKP_INTERVAL = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic [7:0] link_num;
    logic [7:0] lane_num;
    logic       use_pad;
    logic       data_valid;
    logic [7:0] data;
    logic       datak;
    logic       data_ready;
    logic [7:0] txdata;
    logic       txdatak;
    logic       txelecidle;
    logic       ts_done;
    logic       skp_sent;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [8:0] ks;
        bit         idle;
        bit         dat;
        bit         skp0;
        bit         skp3;
        bit         ts;
        bit         ts2;
        int         idx;
    } ent_t;

    ent_t q[$];
    ent_t prev;
    int   tick;
    bit   req;
    int   ts_sets;
    bit   last_ts2;
    bit   took;

    always #5 clk = ~clk;

    ozphy_tx_os_scheduler #(
        .NTS          (NTS),
        .SKP_INTERVAL (SKP_INTERVAL),
        .N_FTS        (8'hFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .link_num   (link_num),
        .lane_num   (lane_num),
        .use_pad    (use_pad),
        .data_valid (data_valid),
        .data       (data),
        .datak      (datak),
        .data_ready (data_ready),
        .txdata     (txdata),
        .txdatak    (txdatak),
        .txelecidle (txelecidle),
        .ts_done    (ts_done),
        .skp_sent   (skp_sent)
    );

    function automatic ent_t blank();
        ent_t e;
        e.ks   = 9'h000;
        e.idle = 1'b0;
        e.dat  = 1'b0;
        e.skp0 = 1'b0;
        e.skp3 = 1'b0;
        e.ts   = 1'b0;
        e.ts2  = 1'b0;
        e.idx  = 0;
        return e;
    endfunction

    function automatic logic [8:0] ts_ref(int i, bit ts2);
        if (i == 0) return 9'h1BC;
        if (i == 1) return use_pad ? 9'h1F7 : {1'b0, link_num};
        if (i == 2) return use_pad ? 9'h1F7 : {1'b0, lane_num};
        if (i == 3) return 9'h0FF;
        if (i == 4) return 9'h002;
        if (i == 5) return 9'h000;
        return ts2 ? 9'h045 : 9'h04A;
    endfunction

    function automatic void model_reset();
        q.delete();
        tick     = 0;
        req      = 1'b0;
        ts_sets  = 0;
        last_ts2 = 1'b0;
        prev     = blank();
    endfunction

    // At a boundary, queue the whole next set chosen by the rules.
    function automatic void push_set();
        ent_t e;
        if (mode == 2'd0) begin
            e = blank();
            e.idle = 1'b1;
            q.push_back(e);
        end else if (req) begin
            for (int i = 0; i < 4; i++) begin
                e = blank();
                e.ks   = (i == 0) ? 9'h1BC : 9'h11C;
                e.skp0 = (i == 0);
                e.skp3 = (i == 3);
                e.idx  = i;
                q.push_back(e);
            end
        end else if (mode == 2'd3) begin
            e = blank();
            e.dat = 1'b1;
            e.ks  = data_valid ? {datak, data} : 9'h000;
            q.push_back(e);
        end else begin
            for (int i = 0; i < 16; i++) begin
                e = blank();
                e.ts  = 1'b1;
                e.ts2 = (mode == 2'd2);
                e.idx = i;
                e.ks  = ts_ref(i, mode == 2'd2);
                q.push_back(e);
            end
        end
    endfunction

    task automatic step(input string tag);
        ent_t e;
        #1;
        if (q.size() == 0) push_set();
        e = q.pop_front();
        took = e.dat && data_valid;
        checks++;
        if (data_ready !== e.dat) begin
            errors++;
            $display("FAIL %s data_ready got %0b want %0b",
                     tag, data_ready, e.dat);
        end
        if (e.idle) begin
            tick    = 0;
            req     = 1'b0;
            ts_sets = 0;
        end else begin
            if (e.skp0) req = 1'b0;
            if (tick == SKP_INTERVAL - 1) begin
                tick = 0;
                req  = 1'b1;
            end else begin
                tick++;
            end
        end
        if (e.ts && e.idx == 0) begin
            if (e.ts2 != last_ts2) ts_sets = 0;
            last_ts2 = e.ts2;
        end
        if (e.ts && e.idx == 15 && ts_sets < NTS) ts_sets++;
        prev = e;
        @(posedge clk);
        #1;
        checks += 5;
        if (txdata !== e.ks[7:0]) begin
            errors++;
            $display("FAIL %s txdata got %h want %h", tag, txdata, e.ks[7:0]);
        end
        if (txdatak !== e.ks[8]) begin
            errors++;
            $display("FAIL %s txdatak got %0b want %0b", tag, txdatak, e.ks[8]);
        end
        if (txelecidle !== e.idle) begin
            errors++;
            $display("FAIL %s txelecidle got %0b want %0b",
                     tag, txelecidle, e.idle);
        end
        if (skp_sent !== e.skp3) begin
            errors++;
            $display("FAIL %s skp_sent got %0b want %0b", tag, skp_sent, e.skp3);
        end
        if (ts_done !== (ts_sets == NTS)) begin
            errors++;
            $display("FAIL %s ts_done got %0b want %0b",
                     tag, ts_done, ts_sets == NTS);
        end
    endtask

    task automatic to_boundary(input string tag);
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            step(tag);
            n++;
        end
    endtask

    task automatic wait_ts_idx(input string tag, input int idx);
        int n = 0;
        while (!(prev.ts && prev.idx == idx) && n < 200) begin
            step(tag);
            n++;
        end
        checks++;
        if (!(prev.ts && prev.idx == idx)) begin
            errors++;
            $display("FAIL %s timeout got idx %0d want %0d", tag, prev.idx, idx);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        mode       = 2'd0;
        link_num   = 8'h00;
        lane_num   = 8'h00;
        use_pad    = 1'b0;
        data_valid = 1'b0;
        data       = 8'h00;
        datak      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 6;
        if (txelecidle !== 1'b1) begin
            errors++;
            $display("FAIL reset txelecidle got %0b want 1", txelecidle);
        end
        if (txdata !== 8'h00) begin
            errors++;
            $display("FAIL reset txdata got %h want 00", txdata);
        end
        if (txdatak !== 1'b0) begin
            errors++;
            $display("FAIL reset txdatak got %0b want 0", txdatak);
        end
        if (data_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset data_ready got %0b want 0", data_ready);
        end
        if (ts_done !== 1'b0) begin
            errors++;
            $display("FAIL reset ts_done got %0b want 0", ts_done);
        end
        if (skp_sent !== 1'b0) begin
            errors++;
            $display("FAIL reset skp_sent got %0b want 0", skp_sent);
        end
        reset = 1'b0;
        model_reset();
        repeat (8) step("idle");
    endtask

    task automatic test_ts_pad();
        use_pad  = 1'b1;
        link_num = 8'($urandom);
        lane_num = 8'($urandom);
        mode     = 2'd1;
        repeat (100) step("ts1_pad");
    endtask

    task automatic test_ts_switch();
        to_boundary("ts_switch");
        use_pad  = 1'b0;
        link_num = 8'($urandom);
        lane_num = 8'($urandom);
        mode     = 2'd1;
        wait_ts_idx("ts_switch", 7);
        mode = 2'd2;
        repeat (90) step("ts_switch");
    endtask

    task automatic test_skp();
        int dut_p = 0;
        int mod_p = 0;
        mode = 2'd0;
        repeat (3) step("skp");
        mode = 2'd1;
        repeat (130) begin
            step("skp");
            if (skp_sent === 1'b1) dut_p++;
            if (prev.skp3) mod_p++;
        end
        checks++;
        if (dut_p != mod_p) begin
            errors++;
            $display("FAIL skp_count got %0d want %0d", dut_p, mod_p);
        end
    endtask

    task automatic test_data();
        to_boundary("data");
        mode       = 2'd3;
        data       = 8'h11;
        datak      = 1'b0;
        data_valid = 1'b1;
        repeat (100) begin
            step("data_seq");
            if (took) data = data + 8'd1;
        end
        data_valid = 1'b0;
        repeat (6) step("data_lidle");
        repeat (80) begin
            data_valid = 1'($urandom_range(0, 1));
            data       = 8'($urandom);
            datak      = 1'($urandom_range(0, 1));
            step("data_rand");
        end
    endtask

    task automatic test_random();
        repeat (400) begin
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            if (q.size() == 0 && $urandom_range(0, 3) == 0) begin
                use_pad  = 1'($urandom_range(0, 1));
                link_num = 8'($urandom);
                lane_num = 8'($urandom);
            end
            data_valid = 1'($urandom_range(0, 1));
            data       = 8'($urandom);
            datak      = 1'($urandom_range(0, 1));
            step("random");
        end
    endtask

    task automatic test_reset_mid();
        to_boundary("rst_mid");
        use_pad = 1'b1;
        mode    = 2'd1;
        repeat (90) step("rst_mid");
        wait_ts_idx("rst_mid", 9);
        reset = 1'b1;
        #1;
        checks += 4;
        if (txelecidle !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid txelecidle got %0b want 1", txelecidle);
        end
        if (txdata !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid txdata got %h want 00", txdata);
        end
        if (txdatak !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid txdatak got %0b want 0", txdatak);
        end
        if (ts_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid ts_done got %0b want 0", ts_done);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        repeat (40) step("rst_resume");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ts_pad();
        test_ts_switch();
        test_skp();
        test_data();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
